// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and payload types for the normalize/round/pack stage
package fp_pkg;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 24;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam int LZ_W    = MAN_W + 2;
  localparam int LZ_CW   = $clog2(LZ_W + 1);
  typedef logic signed [EXP_W+1:0] exp_t;
  typedef struct packed {
    logic             sign;
    exp_t             e;
    logic [MAN_W-1:0] m;
    logic             g;
    logic             r;
    logic             s;
    logic             zero;
  } norm_t;
  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } flags_t;
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero count, all-zero input yields W
module fp_lzc #(
  parameter int W  = 26,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);
  // scan upward so the highest set bit makes the final assignment
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) if (d[i]) cnt = CW'(W - 1 - i);
  end
endmodule

// File: rtl/fp_norm_round_pack.sv
// fp_norm_round_pack: two-stage normalize then round-to-nearest-even and pack to binary32
module fp_norm_round_pack
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_co,
  input  logic [MAN_W-1:0] in_man,
  input  logic [2:0]       in_grs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_inx
);
  logic             s1_valid, s2_adv;
  norm_t            s1_d, s1_q;
  logic [LZ_W-1:0]  w, ws;
  logic [LZ_CW-1:0] lz;
  logic             up, lost;
  logic [MAN_W:0]   m2;
  logic [MAN_W-1:0] mf;
  exp_t             ef;
  logic [31:0]      res_d;
  flags_t           fl_d, fl_q;
  assign s2_adv   = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_adv;
  assign w        = {in_man, in_grs[2:1]};
  assign ws       = w << lz;
  fp_lzc #(.W(LZ_W)) u_lzc (.d(w), .cnt(lz));
  // normalize: carry-out shifts right by one, otherwise shift left by the leading-zero count
  always_comb begin
    s1_d.sign = in_sign;
    s1_d.zero = !in_co && w == '0;
    s1_d.e    = in_co ? exp_t'(in_exp) + exp_t'(1) : exp_t'(in_exp) - exp_t'(lz);
    s1_d.m    = in_co ? {1'b1, in_man[MAN_W-1:1]} : ws[LZ_W-1:2];
    s1_d.g    = in_co ? in_man[0] : ws[1];
    s1_d.r    = in_co ? in_grs[2] : ws[0];
    s1_d.s    = in_co ? |in_grs[1:0] : in_grs[0];
  end
  // round to nearest even, renormalize on mantissa carry, then classify zero/overflow/underflow
  always_comb begin
    up    = s1_q.g & (s1_q.r | s1_q.s | s1_q.m[0]);
    m2    = {1'b0, s1_q.m} + (MAN_W+1)'(up);
    mf    = m2[MAN_W] ? m2[MAN_W:1] : m2[MAN_W-1:0];
    ef    = s1_q.e + exp_t'(m2[MAN_W]);
    lost  = s1_q.g | s1_q.r | s1_q.s;
    res_d = {s1_q.sign, ef[EXP_W-1:0], mf[MAN_W-2:0]};
    fl_d  = '{ovf: 1'b0, unf: 1'b0, inx: lost};
    if (s1_q.zero) res_d = '0;
    else if (ef >= exp_t'(EXP_MAX)) begin
      res_d = {s1_q.sign, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
      fl_d  = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
    end else if (ef <= exp_t'(0)) begin
      res_d = {s1_q.sign, 31'h0};
      fl_d  = '{ovf: 1'b0, unf: 1'b1, inx: (|mf) | lost};
    end
  end
  // S1 pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end
  // S2 output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      fl_q      <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_res <= res_d;
        fl_q    <= fl_d;
      end
    end
  end
  assign out_ovf = fl_q.ovf;
  assign out_unf = fl_q.unf;
  assign out_inx = fl_q.inx;
endmodule

// File: tb/tb_fp_norm_round_pack.sv
// tb_fp_norm_round_pack: directed scoreboard bench for the normalize/round/pack stage
module tb_fp_norm_round_pack;
  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_rec_t;
  logic        clk, rst_n, in_valid, in_ready, in_sign, in_co, out_valid, out_ready;
  logic        out_ovf, out_unf, out_inx;
  logic [7:0]  in_exp;
  logic [23:0] in_man;
  logic [2:0]  in_grs;
  logic [31:0] out_res, snap;
  exp_rec_t    sb[$];
  int          checks = 0, failures = 0;
  fp_norm_round_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_co(in_co), .in_man(in_man), .in_grs(in_grs),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_inx(out_inx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic send(input logic sg, input logic [7:0] e, input logic co, input logic [23:0] m,
                      input logic [2:0] grs, input logic [31:0] res, input logic [2:0] fl);
    bit ok = 1'b0;
    @(negedge clk);
    in_sign = sg; in_exp = e; in_co = co; in_man = m; in_grs = grs; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        sb.push_back('{res, fl});
        #1 in_valid = 1'b0;
      end else @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    assert (ok === 1'b1) else begin failures++; $error("FAIL send_timeout got=%0b want=1", ok); end
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin failures++; $error("FAIL drain got=%0d pending want=0", sb.size()); end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin failures++; $error("FAIL %s got=%h want=%h", tag, got, want); end
  endtask
  // pop and compare each result as it leaves the DUT
  always @(negedge clk) begin
    exp_rec_t x;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin failures++; $error("FAIL sb_empty got=%h want=none", out_res); end
      if (sb.size() != 0) begin
        x = sb.pop_front();
        checks++;
        assert (out_res === x.res) else begin failures++; $error("FAIL res got=%h want=%h", out_res, x.res); end
        checks++;
        assert ({out_ovf, out_unf, out_inx} === x.fl) else begin
          failures++; $error("FAIL flags got=%b want=%b", {out_ovf, out_unf, out_inx}, x.fl);
        end
      end
    end
  end
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_co = 1'b0; in_man = '0; in_grs = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_res", out_res, 32'h0);
    chk("rst_flags", {29'h0, out_ovf, out_unf, out_inx}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    rst_n = 1'b1;
    send(0, 8'd127, 1, 24'h800000, 3'b000, 32'h40400000, 3'b000);
    send(0, 8'd127, 0, 24'h000001, 3'b000, 32'h34000000, 3'b000);
    send(0, 8'd127, 0, 24'hFFFFFF, 3'b100, 32'h40000000, 3'b001);
    send(0, 8'd127, 0, 24'h800000, 3'b100, 32'h3F800000, 3'b001);
    send(0, 8'd127, 0, 24'h800001, 3'b100, 32'h3F800002, 3'b001);
    send(1, 8'd254, 1, 24'h800000, 3'b000, 32'hFF800000, 3'b101);
    send(0, 8'd1,   0, 24'h400000, 3'b000, 32'h00000000, 3'b011);
    send(0, 8'd127, 0, 24'h800000, 3'b101, 32'h3F800001, 3'b001);
    send(0, 8'd127, 1, 24'h800001, 3'b000, 32'h40400000, 3'b001);
    send(0, 8'd127, 1, 24'h800003, 3'b000, 32'h40400002, 3'b001);
    send(0, 8'd127, 0, 24'h400000, 3'b110, 32'h3F000002, 3'b001);
    send(0, 8'd254, 0, 24'hFFFFFF, 3'b100, 32'h7F800000, 3'b101);
    send(0, 8'd100, 0, 24'h000000, 3'b001, 32'h00000000, 3'b001);
    send(1, 8'd100, 0, 24'h000000, 3'b000, 32'h00000000, 3'b000);
    drain();
    set_ready(1'b0);
    send(0, 8'd127, 1, 24'h800000, 3'b000, 32'h40400000, 3'b000);
    send(0, 8'd127, 0, 24'h000001, 3'b000, 32'h34000000, 3'b000);
    @(negedge clk);
    chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
    chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
    chk("stall_head", out_res, 32'h40400000);
    snap = out_res;
    fork
      send(0, 8'd127, 0, 24'hFFFFFF, 3'b100, 32'h40000000, 3'b001);
      begin
        repeat (3) @(negedge clk);
        chk("stall_hold", out_res, snap);
        chk("stall_hold_valid", {31'h0, out_valid}, 32'h1);
        set_ready(1'b1);
      end
    join
    drain();
    set_ready(1'b0);
    send(0, 8'd127, 1, 24'h800000, 3'b000, 32'h40400000, 3'b000);
    send(0, 8'd127, 0, 24'h000001, 3'b000, 32'h34000000, 3'b000);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_out_res", out_res, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    send(0, 8'd127, 0, 24'h800001, 3'b100, 32'h3F800002, 3'b001);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
